pe_spad_loader: RTL and testbench

- Sits directly downstream of the PE input FIFO (64-bit read side) and feeds the PE scratchpad (16-bit write port).
- On a start command it pops packed FIFO words and unpacks each into 16-bit lanes.
- Writes exactly num_words lanes into consecutive scratchpad addresses from base_addr, with wrap-around.
- Flags completion with a one-cycle done pulse.

---
 rtl/pe_spad_loader.sv | 141 ++++++++++++++
 tb/tb_pe_spad_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_spad_loader.sv
// Unpacks wide PE input-FIFO words into 16-bit scratchpad lanes: num_words lanes are
// written to consecutive addresses starting at base_addr, and the address wraps at SPAD_DEPTH.
module pe_spad_loader #(
    parameter int FIFO_DATA_WIDTH = 64,
    parameter int SPAD_DATA_WIDTH = 16,
    parameter int SPAD_DEPTH      = 12,
    parameter int LEN_WIDTH       = 8,
    localparam int RATIO           = FIFO_DATA_WIDTH / SPAD_DATA_WIDTH,
    localparam int SPAD_ADDR_WIDTH = $clog2(SPAD_DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [LEN_WIDTH-1:0]       num_words,
    input  logic [SPAD_ADDR_WIDTH-1:0] base_addr,
    input  logic                       fifo_empty,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_rd_data,
    output logic                       fifo_read_request,
    input  logic                       spad_stall,
    output logic                       spad_wr_en,
    output logic [SPAD_ADDR_WIDTH-1:0] spad_wr_addr,
    output logic [SPAD_DATA_WIDTH-1:0] spad_wr_data,
    output logic                       busy,
    output logic                       done
);

    // state  | meaning
    // IDLE   | waiting for start; num_words and base_addr are latched on start
    // FETCH  | pop one FIFO word as soon as the FIFO is non-empty
    // WAIT   | FIFO read data is valid now; capture it into word_reg
    // UNPACK | write one lane per non-stalled cycle
    // DONE   | single-cycle completion pulse
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        UNPACK = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int LANE_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_WIDTH-1:0]      LAST_LANE = LANE_WIDTH'(RATIO - 1);
    localparam logic [SPAD_ADDR_WIDTH-1:0] LAST_ADDR = SPAD_ADDR_WIDTH'(SPAD_DEPTH - 1);

    state_t                     state;
    state_t                     state_next;
    logic [LEN_WIDTH-1:0]       remaining;
    logic [SPAD_ADDR_WIDTH-1:0] addr_reg;
    logic [FIFO_DATA_WIDTH-1:0] word_reg;
    logic [LANE_WIDTH-1:0]      lane_idx;
    logic [SPAD_DATA_WIDTH-1:0] lanes [RATIO];

    for (genvar g = 0; g < RATIO; g++) begin : g_lane
        assign lanes[g] = word_reg[g*SPAD_DATA_WIDTH +: SPAD_DATA_WIDTH];
    end

    assign spad_wr_addr = addr_reg;
    assign spad_wr_data = lanes[lane_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next        = state;
        fifo_read_request = 1'b0;
        spad_wr_en        = 1'b0;
        busy              = (state != IDLE);
        done              = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_words == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (!fifo_empty) begin
                    fifo_read_request = 1'b1;
                    state_next        = WAIT;
                end
            end
            WAIT: begin
                state_next = UNPACK;
            end
            UNPACK: begin
                if (!spad_stall) begin
                    spad_wr_en = 1'b1;
                    // Finishing mid-word simply drops the unused upper lanes.
                    if (remaining == LEN_WIDTH'(1)) begin
                        state_next = DONE;
                    end else if (lane_idx == LAST_LANE) begin
                        state_next = FETCH;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
            addr_reg  <= '0;
            word_reg  <= '0;
            lane_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= num_words;
                        addr_reg  <= base_addr;
                    end
                end
                WAIT: begin
                    word_reg <= fifo_rd_data;
                    lane_idx <= '0;
                end
                UNPACK: begin
                    if (!spad_stall) begin
                        remaining <= remaining - LEN_WIDTH'(1);
                        addr_reg  <= (addr_reg == LAST_ADDR) ? '0 : addr_reg + SPAD_ADDR_WIDTH'(1);
                        lane_idx  <= lane_idx + LANE_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_spad_loader.sv
// Bench for pe_spad_loader: a cycle table for a basic load, hand-written corner sequences,
// and randomized loads checked against a list-based model of the expected writes.
module tb_pe_spad_loader;

    localparam int RATIO = 4;
    localparam int DEPTH = 12;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  num_words;
    logic [3:0]  base_addr;
    logic        fifo_empty;
    logic [63:0] fifo_rd_data;
    logic        fifo_read_request;
    logic        spad_stall;
    logic        spad_wr_en;
    logic [3:0]  spad_wr_addr;
    logic [15:0] spad_wr_data;
    logic        busy;
    logic        done;

    pe_spad_loader dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .num_words         (num_words),
        .base_addr         (base_addr),
        .fifo_empty        (fifo_empty),
        .fifo_rd_data      (fifo_rd_data),
        .fifo_read_request (fifo_read_request),
        .spad_stall        (spad_stall),
        .spad_wr_en        (spad_wr_en),
        .spad_wr_addr      (spad_wr_addr),
        .spad_wr_data      (spad_wr_data),
        .busy              (busy),
        .done              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [63:0] fq[$];
    logic [63:0] words[$];
    logic [3:0]  log_addr[$];
    logic [15:0] log_data[$];
    int pops  = 0;
    int dones = 0;

    // FIFO and scratchpad models: read data is valid the cycle after an accepted pop.
    always @(posedge clk) begin
        if (reset) begin
            if (fifo_read_request) begin
                if (fq.size() > 0) fifo_rd_data <= fq.pop_front();
                pops++;
            end
            if (spad_wr_en) begin
                log_addr.push_back(spad_wr_addr);
                log_data.push_back(spad_wr_data);
            end
            if (done) dones++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic st, input logic stl, input logic hold_empty);
        @(negedge clk);
        start      = st;
        spad_stall = stl;
        fifo_empty = hold_empty || (fq.size() == 0);
        #1;
    endtask

    task automatic wait_done(input int stall_pct, input int empty_pct);
        bit seen;
        seen = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 99) < stall_pct,
                 $urandom_range(0, 99) < empty_pct);
            if (done) seen = 1;
        end
        chk("done_seen", 64'(seen), 64'd1);
        tick(1'b0, 1'b0, 1'b0);
        chk("idle_after_done", {busy, done}, 64'd0);
    endtask

    // Reference: lane i of the load is 16-bit slice (i mod RATIO) of word i/RATIO, at (base+i) mod DEPTH.
    task automatic compare_log(input int n, input int base, input int log0, input int pops0,
                               input int dones0);
        logic [63:0] w;
        chk("n_writes", 64'(log_addr.size() - log0), 64'(n));
        chk("n_pops", 64'(pops - pops0), 64'((n + RATIO - 1) / RATIO));
        chk("n_dones", 64'(dones - dones0), 64'd1);
        for (int i = 0; i < n && (log0 + i) < log_addr.size(); i++) begin
            w = words[i / RATIO];
            chk($sformatf("wr_addr[%0d]", i), 64'(log_addr[log0 + i]), 64'((base + i) % DEPTH));
            chk($sformatf("wr_data[%0d]", i), 64'(log_data[log0 + i]), 64'(w[16*(i % RATIO) +: 16]));
        end
    endtask

    typedef struct {
        logic        start;
        logic        rr;
        logic        we;
        logic [3:0]  addr;
        logic [15:0] data;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl[9];
    int log0, pops0, dones0, n, base;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 4'd0, 16'd0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 4'd0, 16'd1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 4'd1, 16'd2, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 4'd2, 16'd3, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 4'd3, 16'd4, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0};

        reset = 1'b0; start = 1'b0; num_words = '0; base_addr = '0;
        fifo_empty = 1'b1; spad_stall = 1'b0; fifo_rd_data = '0;
        tick(1'b0, 1'b0, 1'b0);
        chk("reset_outputs", {fifo_read_request, spad_wr_en, busy, done, spad_wr_addr, spad_wr_data}, 64'd0);
        @(negedge clk); reset = 1'b1;

        // Cycle-exact single-word load.
        words = '{64'h0004_0003_0002_0001};
        fq = words; num_words = 8'd4; base_addr = 4'd0;
        pops0 = pops;
        for (int i = 0; i < 9; i++) begin
            tick(tbl[i].start, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_rr", i), 64'(fifo_read_request), 64'(tbl[i].rr));
            chk($sformatf("tbl%0d_we", i), 64'(spad_wr_en), 64'(tbl[i].we));
            chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].busy));
            chk($sformatf("tbl%0d_done", i), 64'(done), 64'(tbl[i].done));
            if (tbl[i].we) begin
                chk($sformatf("tbl%0d_addr", i), 64'(spad_wr_addr), 64'(tbl[i].addr));
                chk($sformatf("tbl%0d_data", i), 64'(spad_wr_data), 64'(tbl[i].data));
            end
        end
        chk("tbl_pops", 64'(pops - pops0), 64'd1);

        // Two words, partial second word.
        words = '{64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005};
        fq = words; num_words = 8'd6; base_addr = 4'd0;
        log0 = log_addr.size(); pops0 = pops; dones0 = dones;
        tick(1'b1, 1'b0, 1'b0);
        wait_done(0, 0);
        compare_log(6, 0, log0, pops0, dones0);

        // Address wrap.
        words = '{64'h00dd_00cc_00bb_00aa};
        fq = words; num_words = 8'd4; base_addr = 4'd10;
        log0 = log_addr.size(); pops0 = pops; dones0 = dones;
        tick(1'b1, 1'b0, 1'b0);
        wait_done(0, 0);
        compare_log(4, 10, log0, pops0, dones0);

        // FIFO empty for 5 cycles after start.
        words = '{64'hdead_beef_cafe_f00d};
        fq = words; num_words = 8'd4; base_addr = 4'd2;
        log0 = log_addr.size(); pops0 = pops; dones0 = dones;
        tick(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            chk("empty_rr", 64'(fifo_read_request), 64'd0);
            chk("empty_busy", 64'(busy), 64'd1);
        end
        tick(1'b0, 1'b0, 1'b0);
        chk("empty_release_rr", 64'(fifo_read_request), 64'd1);
        wait_done(0, 0);
        compare_log(4, 2, log0, pops0, dones0);

        // Stall for 3 cycles on lane 1.
        words = '{64'h4444_3333_2222_1111};
        fq = words; num_words = 8'd4; base_addr = 4'd7;
        log0 = log_addr.size(); pops0 = pops; dones0 = dones;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("stall_lane0_we", 64'(spad_wr_en), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            chk("stall_we", 64'(spad_wr_en), 64'd0);
            chk("stall_addr", 64'(spad_wr_addr), 64'd8);
            chk("stall_data", 64'(spad_wr_data), 64'h2222);
        end
        tick(1'b0, 1'b0, 1'b0);
        chk("post_stall_we", {spad_wr_en, spad_wr_addr, spad_wr_data}, {1'b1, 4'd8, 16'h2222});
        wait_done(0, 0);
        compare_log(4, 7, log0, pops0, dones0);

        // Zero-length load: a waiting FIFO word must not be popped.
        words.delete();
        fq = '{64'h1234};
        num_words = 8'd0; base_addr = 4'd5;
        log0 = log_addr.size(); pops0 = pops; dones0 = dones;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("zero_done", {fifo_read_request, spad_wr_en, done}, 64'b001);
        tick(1'b0, 1'b0, 1'b0);
        chk("zero_idle", 64'(busy), 64'd0);
        chk("zero_writes", 64'(log_addr.size() - log0), 64'd0);
        chk("zero_pops", 64'(pops - pops0), 64'd0);
        chk("zero_dones", 64'(dones - dones0), 64'd1);
        fq.delete();

        // Reset during UNPACK, then a clean restart.
        words = '{64'h0d0d_0c0c_0b0b_0a0a};
        fq = words; num_words = 8'd4; base_addr = 4'd3;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        @(negedge clk); reset = 1'b0; #1;
        chk("midreset_outputs", {fifo_read_request, spad_wr_en, busy, done, spad_wr_addr, spad_wr_data}, 64'd0);
        @(negedge clk); reset = 1'b1;
        words = '{64'h9999_8888_7777_6666};
        fq = words; num_words = 8'd4; base_addr = 4'd9;
        log0 = log_addr.size(); pops0 = pops; dones0 = dones;
        tick(1'b1, 1'b0, 1'b0);
        wait_done(0, 0);
        compare_log(4, 9, log0, pops0, dones0);

        // Randomized loads with random stalls, FIFO gaps and stray starts.
        for (int t = 0; t < 30; t++) begin
            n = $urandom_range(0, 20);
            base = $urandom_range(0, DEPTH - 1);
            words.delete();
            for (int k = 0; k < (n + RATIO - 1) / RATIO; k++) words.push_back({$urandom, $urandom});
            fq = words; num_words = 8'(n); base_addr = 4'(base);
            log0 = log_addr.size(); pops0 = pops; dones0 = dones;
            tick(1'b1, 1'b0, 1'b0);
            wait_done(25, 25);
            compare_log(n, base, log0, pops0, dones0);
            chk("fifo_drained", 64'(fq.size()), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
